// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle datapath and its control FSM.
// The master modport is the controller side; slave is the datapath side.
interface mc_control_fsm_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       memReady;

    logic       pcWrite;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    logic       illegal;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [3:0] state;

    modport master (
        input  op, funct3, zero, memReady,
        output pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal,
        output resultSrc, aluSrcA, aluSrcB, aluOp, state
    );

    modport slave (
        output op, funct3, zero, memReady,
        input  pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal,
        input  resultSrc, aluSrcA, aluSrcB, aluOp, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Moore control FSM for a multicycle RISC-V core (load/store/R/I/branch/JAL).
// Define MC_MEM_WAIT_EN to hold FETCH, MEMREAD and MEMWRITE until memReady=1.
module mc_control_fsm (
    input  logic              clk,
    input  logic              rst,
    mc_control_fsm_if.master  bus
);

`ifdef MC_MEM_WAIT_EN
    localparam bit MemWaitEn = 1'b1;
`else
    localparam bit MemWaitEn = 1'b0;
`endif

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    state_e state_q, state_d;
    logic   mem_ready;
    logic   taken;

    assign mem_ready = MemWaitEn ? bus.memReady : 1'b1;

    always_comb begin
        unique case (bus.funct3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = ~bus.zero;
            default: taken = 1'b0;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OpLoad, OpStore: state_d = S_MEMADR;
                    OpR:             state_d = S_EXECR;
                    OpI:             state_d = S_EXECI;
                    OpBranch:        state_d = S_BRANCH;
                    OpJal:           state_d = S_JAL;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OpLoad) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Outputs decode the current state combinationally: branch pcWrite needs the
    // zero flag of this cycle, and wait-state FETCH strobes need this cycle's memReady.
    always_comb begin
        bus.pcWrite   = 1'b0;
        bus.adrSrc    = 1'b0;
        bus.memWrite  = 1'b0;
        bus.irWrite   = 1'b0;
        bus.regWrite  = 1'b0;
        bus.illegal   = 1'b0;
        bus.resultSrc = 2'b00;
        bus.aluSrcA   = 2'b00;
        bus.aluSrcB   = 2'b00;
        bus.aluOp     = 2'b00;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.irWrite   = mem_ready;
                    bus.pcWrite   = mem_ready;
                    bus.aluSrcB   = 2'b10;
                    bus.resultSrc = 2'b10;
                end
                S_DECODE: begin
                    bus.aluSrcA = 2'b01;
                    bus.aluSrcB = 2'b01;
                    bus.illegal = !(bus.op inside {OpLoad, OpStore, OpR, OpI, OpBranch, OpJal});
                end
                S_MEMADR: begin
                    bus.aluSrcA = 2'b10;
                    bus.aluSrcB = 2'b01;
                end
                S_MEMREAD:  bus.adrSrc = 1'b1;
                S_MEMWB: begin
                    bus.resultSrc = 2'b01;
                    bus.regWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    bus.adrSrc   = 1'b1;
                    bus.memWrite = 1'b1;
                end
                S_EXECR: begin
                    bus.aluSrcA = 2'b10;
                    bus.aluOp   = 2'b10;
                end
                S_EXECI: begin
                    bus.aluSrcA = 2'b10;
                    bus.aluSrcB = 2'b01;
                    bus.aluOp   = 2'b10;
                end
                S_ALUWB:    bus.regWrite = 1'b1;
                S_BRANCH: begin
                    bus.aluSrcA = 2'b10;
                    bus.aluOp   = 2'b01;
                    bus.pcWrite = taken;
                end
                S_JAL: begin
                    bus.aluSrcA = 2'b01;
                    bus.aluSrcB = 2'b10;
                    bus.pcWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.state = state_q;

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, rising-edge.
REQ-002 SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: op  input  7  instruction opcode from instruction register.
REQ-004 SHALL have ports: funct3  input  3  instruction funct3.
REQ-005 SHALL have ports: zero  input  1  ALU zero flag.
REQ-006 SHALL have ports: memReady  input  1  memory access complete.
REQ-007 SHALL have outputs, each 1 bit: pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal.
REQ-008 SHALL have outputs, each 2 bits: resultSrc, aluSrcA, aluSrcB, aluOp (aluOp feeds the team's ALU decoder: 00 add, 01 funct3, 10 R/I decode).
REQ-009 SHALL have output: state  4 bits  current state encoding, for debug.

Function
REQ-010 SHALL be a Moore FSM advancing on rising clk; state encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10; codes 11-15 go to FETCH next cycle.
REQ-011 SHALL use these transitions:
- FETCH->DECODE.
- DECODE by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; other -> FETCH.
- MEMADR->MEMREAD (op=0000011) else MEMWRITE.
- MEMREAD->MEMWB; EXECR and EXECI->ALUWB; JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH.
REQ-012 SHALL drive outputs per state (unlisted outputs 0):
- FETCH: irWrite=1, pcWrite=1, aluSrcB=10, resultSrc=10.
- DECODE: aluSrcA=01, aluSrcB=01.
- MEMADR: aluSrcA=10, aluSrcB=01.
- MEMREAD: adrSrc=1.
- MEMWB: resultSrc=01, regWrite=1.
- MEMWRITE: adrSrc=1, memWrite=1.
- EXECR: aluSrcA=10, aluOp=10.
- EXECI: aluSrcA=10, aluSrcB=01, aluOp=10.
- ALUWB: regWrite=1.
- BRANCH: aluSrcA=10, aluOp=01, pcWrite=taken.
- JAL: aluSrcA=01, aluSrcB=10, pcWrite=1.
REQ-013 SHALL define taken = (funct3=000 and zero=1) or (funct3=001 and zero=0); other funct3 values give taken=0.
REQ-014 SHALL pulse illegal=1 for exactly the DECODE cycle that holds an unsupported opcode.
REQ-015 SHALL make instruction latency 3 cycles for branch, 4 for R/I/JAL/store, and 5 for load, excluding wait cycles.

Reset
REQ-016 SHALL force state=FETCH immediately on rst assertion, independent of clk.
REQ-017 SHALL hold all control outputs and illegal at 0 while rst=1; state output reads 0.
REQ-018 SHALL abandon any in-flight instruction on reset mid-operation; the first cycle after deassertion is FETCH with no stale memWrite or regWrite.

Configuration
REQ-019 SHALL compile in memory wait-state support when macro MC_MEM_WAIT_EN is defined.
REQ-020 SHALL, with MC_MEM_WAIT_EN defined, hold FETCH, MEMREAD and MEMWRITE while memReady=0:
- FETCH asserts irWrite and pcWrite only in the cycle memReady=1.
- MEMWRITE keeps memWrite=1 throughout the wait.
REQ-021 SHALL, without MC_MEM_WAIT_EN, ignore memReady, and every state SHALL last exactly one cycle.

Verification
REQ-022 SHALL cover: rst pulse in MEMWRITE -> state=0 at once, memWrite=0; next FETCH one cycle after deassertion.
REQ-023 SHALL cover: op=0000011 stream -> states 0,1,2,3,4,0; regWrite=1 only in state 4.
REQ-024 SHALL cover: op=1100011, funct3=001, zero=0 -> pcWrite=1 in BRANCH; with zero=1 -> pcWrite=0.
REQ-025 SHALL cover: op=1111111 -> illegal=1 for one cycle in DECODE, then FETCH.
REQ-026 SHALL cover: with MC_MEM_WAIT_EN, memReady=0 for 3 cycles in FETCH -> state holds 0 for 4 cycles; irWrite=1 only in the last cycle.
REQ-027 SHALL cover: op=0110011 -> aluOp=10 with aluSrcA=10 in EXECR, then ALUWB regWrite=1, total 4 cycles.
